fp_adder_arbiter: RTL and testbench
===================================

// Module: fp_adder_arbiter
// PURPOSE
//  Shares one fp_adder_sig instance (AXI-Stream a/b operand channels in, result channel out) among
//  NUM_REQ requesters. Round-robin arbitration, operand issue to the adder, and in-order return of
//  each result to the requester that issued it via a tag FIFO. Sits between the test/requester
//  logic and the adder in top-level benches and in the compute path.
// PARAMETERS
//  NUM_REQ    4   number of requester ports (2..16)
//  DATA_W     32  operand/result width (IEEE-754 single)
//  TAG_DEPTH  8   max operations in flight inside the adder (power of 2, >=2)
// PORTS
//  i_clk                 in   1              clock; all logic on posedge
//  aresetn               in   1              asynchronous active-low reset
//  req_valid             in   NUM_REQ        requester i has an operand pair
//  req_ready             out  NUM_REQ        requester i pair accepted this cycle
//  req_a                 in   NUM_REQ*DATA_W operand A per requester (slice i)
//  req_b                 in   NUM_REQ*DATA_W operand B per requester (slice i)
//  rsp_valid             out  NUM_REQ        result valid for requester i
//  rsp_ready             in   NUM_REQ        requester i accepts result
//  rsp_data              out  DATA_W         result (shared bus; qualify by rsp_valid[i])
//  m_axis_a_tvalid/tready/tdata   out/in/out 1/1/DATA_W  to adder s_axis_a
//  m_axis_b_tvalid/tready/tdata   out/in/out 1/1/DATA_W  to adder s_axis_b
//  s_axis_result_tvalid/tready/tdata in/out/in 1/1/DATA_W from adder m_axis_result
//  outstanding           out  $clog2(TAG_DEPTH)+1  ops issued, result not yet returned
//  err_orphan            out  1              sticky: adder result arrived with no tag pending
// BEHAVIOUR
//  Reset (aresetn=0, async): state=IDLE, rr_ptr=0, FIFO empty, outstanding=0, err_orphan=0;
//   all req_ready, rsp_valid, m_axis_*_tvalid, s_axis_result_tready = 0. Mid-operation reset
//   discards in-flight tags; adder is reset by the same aresetn.
//  FSM IDLE: grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, .. mod NUM_REQ.
//   If any valid and FIFO not full: req_ready[g]=1 (comb, one-hot, only this cycle), latch
//   req_a[g]/req_b[g], push tag g, go ISSUE. Else stay IDLE, all req_ready=0.
//  ISSUE: m_axis_a_tvalid = !a_done, m_axis_b_tvalid = !b_done, tdata from latches (stable).
//   a_done/b_done set on the respective handshake; channels complete independently in any order.
//   When both complete (incl. same cycle): clear flags, rr_ptr = g+1 mod NUM_REQ, go IDLE.
//  Latency: req handshake -> tvalid next cycle. Peak throughput 1 op / 2 cycles.
//  Return path: head = FIFO head tag. rsp_valid[i] = s_axis_result_tvalid & !empty & (head==i);
//   s_axis_result_tready = !empty & rsp_ready[head]; rsp_data = s_axis_result_tdata (pass-through,
//   zero added latency). Pop FIFO on result handshake.
//  Result while FIFO empty: tready=0, err_orphan<=1 (stays until reset).
//  FIFO full (TAG_DEPTH outstanding): IDLE grants nothing until a pop.
//  Push and pop same cycle: occupancy unchanged, including when full (pop first frees slot).
//  outstanding = FIFO occupancy; +1 on push, -1 on pop, unchanged on both.
//  Pointers wrap mod TAG_DEPTH; occupancy counter disambiguates full/empty.
//  req_ready never asserts for a requester whose req_valid=0.
// STRUCTURE
//  tb_pkg additions: localparam FPA_NUM_REQ/FPA_TAG_DEPTH defaults; typedef logic
//   [$clog2(NUM_REQ)-1:0] fpa_tag_t; typedef enum logic {ARB_IDLE, ARB_ISSUE} fpa_arb_state_t.
//  Sub-module fpa_tag_fifo (sync FIFO of fpa_tag_t: push/pop/full/empty/count/head).
//  Arbiter, FSM, issue latches and return demux in this module.
// TESTING (NUM_REQ=4, DATA_W=32, TAG_DEPTH=8, adder ready always unless stated)
//  1 Single: req 2 a=0x3F800000 b=0x40000000 -> req_ready[2] 1 cycle, a/b tvalid next cycle,
//    rsp_valid[2] only, rsp_data=0x40400000; outstanding 0->1->0.
//  2 Fairness: all 4 valid continuously, 12 ops -> grant order 0,1,2,3,0,1,2,3,...; each result
//    returned to its issuer in issue order.
//  3 Skewed channels: hold m_axis_b_tready=0 for 5 cycles after a accepted -> b tdata unchanged,
//    no new grant until b handshake; FSM then IDLE.
//  4 Backpressure: rsp_ready[1]=0 with head tag 1 -> s_axis_result_tready=0, later results stall;
//    issue continues until outstanding=8, then req_ready all 0; release -> drains in order.
//  5 Orphan: force s_axis_result_tvalid=1 with FIFO empty -> tready=0, err_orphan=1 and sticky.
//  6 Reset mid-op: aresetn=0 with 3 outstanding in ISSUE -> all outputs 0 same cycle,
//    outstanding=0, next grant starts at requester 0.

Source files
------------

// File: rtl/fp_adder_arbiter_pkg.sv
// Shared types and defaults for the fp_adder_arbiter slice: tag type, FSM states,
// and default sizing of requester count, data width and tag FIFO depth.
package fp_adder_arbiter_pkg;

    localparam int unsigned FPA_NUM_REQ   = 4;
    localparam int unsigned FPA_DATA_W    = 32;
    localparam int unsigned FPA_TAG_DEPTH = 8;

    typedef logic [$clog2(FPA_NUM_REQ)-1:0] fpa_tag_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_ISSUE
    } fpa_arb_state_t;

endpackage

// File: rtl/fpa_tag_fifo.sv
// Synchronous FIFO of requester tags with a first-word-fall-through head.
// Pointers wrap naturally (DEPTH is a power of 2); the occupancy counter separates full from empty.
module fpa_tag_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one fp_adder_sig among NUM_REQ requesters: round-robin grant, operand issue on the
// adder's a/b streams, and in-order routing of each result back to its issuer via a tag FIFO.
module fp_adder_arbiter
    import fp_adder_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = FPA_NUM_REQ,
    parameter int unsigned DATA_W    = FPA_DATA_W,
    parameter int unsigned TAG_DEPTH = FPA_TAG_DEPTH
) (
    input  logic                          i_clk,
    input  logic                          aresetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]     req_a,
    input  logic [NUM_REQ*DATA_W-1:0]     req_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          m_axis_a_tvalid,
    input  logic                          m_axis_a_tready,
    output logic [DATA_W-1:0]             m_axis_a_tdata,
    output logic                          m_axis_b_tvalid,
    input  logic                          m_axis_b_tready,
    output logic [DATA_W-1:0]             m_axis_b_tdata,
    input  logic                          s_axis_result_tvalid,
    output logic                          s_axis_result_tready,
    input  logic [DATA_W-1:0]             s_axis_result_tdata,
    output logic [$clog2(TAG_DEPTH):0]    outstanding,
    output logic                          err_orphan
);

    localparam int unsigned TAG_W = $clog2(NUM_REQ);
    localparam logic [TAG_W-1:0] LAST_REQ = TAG_W'(NUM_REQ - 1);

    fpa_arb_state_t state_q, state_d;
    logic [TAG_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0]  grant_q, grant_d;
    logic [DATA_W-1:0] a_lat_q, a_lat_d;
    logic [DATA_W-1:0] b_lat_q, b_lat_d;
    logic              a_done_q, a_done_d;
    logic              b_done_q, b_done_d;
    logic              err_orphan_q, err_orphan_d;

    logic [TAG_W-1:0]  pick;
    logic              pick_found;
    int unsigned       cand;
    logic              a_fin, b_fin;

    logic                       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(TAG_DEPTH):0] fifo_count;
    logic [TAG_W-1:0]           fifo_head;

    fpa_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (i_clk),
        .rst_n     (aresetn),
        .push      (fifo_push),
        .push_data (pick),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Round-robin search starting at rr_ptr, wrapping mod NUM_REQ.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!pick_found && req_valid[TAG_W'(cand)]) begin
                pick_found = 1'b1;
                pick       = TAG_W'(cand);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        a_lat_d         = a_lat_q;
        b_lat_d         = b_lat_q;
        a_done_d        = a_done_q;
        b_done_d        = b_done_q;
        req_ready       = '0;
        fifo_push       = 1'b0;
        m_axis_a_tvalid = 1'b0;
        m_axis_b_tvalid = 1'b0;
        a_fin           = 1'b0;
        b_fin           = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // aresetn gates the combinational grant so req_ready is low throughout reset.
                if (aresetn && pick_found && !fifo_full) begin
                    req_ready[pick] = 1'b1;
                    a_lat_d         = req_a[pick*DATA_W +: DATA_W];
                    b_lat_d         = req_b[pick*DATA_W +: DATA_W];
                    grant_d         = pick;
                    fifo_push       = 1'b1;
                    a_done_d        = 1'b0;
                    b_done_d        = 1'b0;
                    state_d         = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                m_axis_a_tvalid = !a_done_q;
                m_axis_b_tvalid = !b_done_q;
                a_fin = a_done_q || (m_axis_a_tvalid && m_axis_a_tready);
                b_fin = b_done_q || (m_axis_b_tvalid && m_axis_b_tready);
                if (a_fin && b_fin) begin
                    a_done_d = 1'b0;
                    b_done_d = 1'b0;
                    rr_ptr_d = (grant_q == LAST_REQ) ? '0 : grant_q + 1'b1;
                    state_d  = ARB_IDLE;
                end else begin
                    a_done_d = a_fin;
                    b_done_d = b_fin;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Return demux: the FIFO head names the only requester allowed to see the result.
    always_comb begin
        rsp_valid            = '0;
        s_axis_result_tready = 1'b0;
        fifo_pop             = 1'b0;
        err_orphan_d         = err_orphan_q;
        if (!fifo_empty) begin
            rsp_valid[fifo_head] = s_axis_result_tvalid;
            s_axis_result_tready = rsp_ready[fifo_head];
            fifo_pop             = s_axis_result_tvalid && rsp_ready[fifo_head];
        end else if (s_axis_result_tvalid) begin
            err_orphan_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ARB_IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            a_lat_q      <= '0;
            b_lat_q      <= '0;
            a_done_q     <= 1'b0;
            b_done_q     <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            a_lat_q      <= a_lat_d;
            b_lat_q      <= b_lat_d;
            a_done_q     <= a_done_d;
            b_done_q     <= b_done_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign m_axis_a_tdata = a_lat_q;
    assign m_axis_b_tdata = b_lat_q;
    assign rsp_data       = s_axis_result_tdata;
    assign outstanding    = fifo_count;
    assign err_orphan     = err_orphan_q;

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Self-checking bench for fp_adder_arbiter: behavioural single-precision adder on the stream side,
// transaction-level reference for grants, issue, tag order, occupancy and orphan flag.
`timescale 1ns/1ps
module tb_fp_adder_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned TD = 8;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic [NR-1:0]    req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
    logic [NR*DW-1:0] req_a = '0, req_b = '0;
    logic [DW-1:0]    rsp_data, a_tdata, b_tdata, r_tdata;
    logic             a_tvalid, b_tvalid, r_tvalid, r_tready;
    logic             a_tready = 1'b1, b_tready = 1'b1;
    logic [$clog2(TD):0] outstanding;
    logic             err_orphan;
    logic             force_orphan = 1'b0;

    always #5 clk = ~clk;

    fp_adder_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
        .i_clk(clk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .m_axis_a_tvalid(a_tvalid), .m_axis_a_tready(a_tready), .m_axis_a_tdata(a_tdata),
        .m_axis_b_tvalid(b_tvalid), .m_axis_b_tready(b_tready), .m_axis_b_tdata(b_tdata),
        .s_axis_result_tvalid(r_tvalid), .s_axis_result_tready(r_tready),
        .s_axis_result_tdata(r_tdata),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    // ---------------- single-precision arithmetic via real ----------------
    function automatic real f2r(input logic [31:0] x);
        logic [10:0] e;
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        d = {x[31], e, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(f2r(x) + f2r(y));
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        r[30:23] = 8'(120 + $urandom_range(0, 14));
        return r;
    endfunction

    // ---------------- adder model: in-order, one cycle after both operands ----------------
    logic [31:0] amem [1024];
    logic [31:0] bmem [1024];
    int unsigned a_wr, b_wr, r_rd;
    logic        r_avail;

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            a_wr <= 0; b_wr <= 0; r_rd <= 0;
        end else begin
            if (a_tvalid && a_tready) begin amem[a_wr % 1024] <= a_tdata; a_wr <= a_wr + 1; end
            if (b_tvalid && b_tready) begin bmem[b_wr % 1024] <= b_tdata; b_wr <= b_wr + 1; end
            if (r_avail && r_tready) r_rd <= r_rd + 1;
        end
    end

    always_comb begin
        r_avail  = (r_rd < a_wr) && (r_rd < b_wr);
        r_tvalid = force_orphan || r_avail;
        r_tdata  = r_avail ? fadd(amem[r_rd % 1024], bmem[r_rd % 1024]) : 32'hDEADBEEF;
    end

    // ---------------- reference model state ----------------
    bit          m_issuing, m_a_done, m_b_done, m_orphan;
    int unsigned m_ptr, m_grant, m_cnt;
    logic [31:0] m_lat_a, m_lat_b;
    int unsigned tag_q[$];
    logic [31:0] exp_q[NR][$];
    int unsigned obs_glog[$];
    bit          refresh[NR];
    int          tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int unsigned p);
        for (int k = 0; k < NR; k++)
            if (v[(p + k) % NR]) return int'((p + k) % NR);
        return -1;
    endfunction

    task automatic model_reset();
        m_issuing = 0; m_a_done = 0; m_b_done = 0; m_orphan = 0;
        m_ptr = 0; m_grant = 0; m_cnt = 0;
        tag_q.delete();
        for (int i = 0; i < NR; i++) exp_q[i].delete();
    endtask

    task automatic check_outputs();
        int          g;
        logic [NR-1:0] exp_rdy, exp_rv;
        bit          ne;
        int unsigned h;
        g = rr_pick(req_valid, m_ptr);
        exp_rdy = '0;
        if (!m_issuing && g >= 0 && m_cnt < TD) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("a_tvalid", a_tvalid, m_issuing && !m_a_done);
        chk("b_tvalid", b_tvalid, m_issuing && !m_b_done);
        if (m_issuing && !m_a_done) chk("a_tdata", a_tdata, m_lat_a);
        if (m_issuing && !m_b_done) chk("b_tdata", b_tdata, m_lat_b);
        ne = tag_q.size() > 0;
        h  = ne ? tag_q[0] : 0;
        exp_rv = '0;
        if (ne && r_tvalid) exp_rv[h] = 1'b1;
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("result_tready", r_tready, ne && rsp_ready[h]);
        if (ne && r_tvalid) chk("rsp_data", rsp_data, exp_q[h][0]);
        chk("outstanding", outstanding, m_cnt);
        chk("err_orphan", err_orphan, m_orphan);
    endtask

    task automatic record();
        int          g;
        bit          ne, grant_ok;
        int unsigned h;
        g = rr_pick(req_valid, m_ptr);
        grant_ok = !m_issuing && g >= 0 && m_cnt < TD;
        for (int i = 0; i < NR; i++) if (req_ready[i]) obs_glog.push_back(i);
        ne = tag_q.size() > 0;
        h  = ne ? tag_q[0] : 0;
        if (ne && r_tvalid && rsp_ready[h]) begin
            void'(tag_q.pop_front());
            void'(exp_q[h].pop_front());
            m_cnt--;
        end
        if (!ne && r_tvalid) m_orphan = 1'b1;
        if (m_issuing) begin
            if (a_tready) m_a_done = 1'b1;
            if (b_tready) m_b_done = 1'b1;
            if (m_a_done && m_b_done) begin
                m_issuing = 0; m_a_done = 0; m_b_done = 0;
                m_ptr = (m_grant + 1) % NR;
            end
        end else if (grant_ok) begin
            m_issuing = 1; m_a_done = 0; m_b_done = 0;
            m_grant = g;
            m_lat_a = req_a[g*DW +: DW];
            m_lat_b = req_b[g*DW +: DW];
            tag_q.push_back(g);
            exp_q[g].push_back(fadd(m_lat_a, m_lat_b));
            m_cnt++;
            refresh[g] = 1;
        end
    endtask

    // Called just after a negedge; inputs set by the caller are stable until the next posedge.
    task automatic tick();
        #1;
        check_outputs();
        record();
        @(negedge clk);
        for (int i = 0; i < NR; i++) if (refresh[i]) begin
            req_a[i*DW +: DW] = rand_op();
            req_b[i*DW +: DW] = rand_op();
            refresh[i] = 0;
        end
    endtask

    task automatic drain();
        req_valid = '0;
        for (int k = 0; k < 80 && (m_cnt != 0 || m_issuing); k++) tick();
        #1 chk("drain_outstanding", outstanding, 0);
    endtask

    initial begin
        bit          seen;
        int unsigned start;

        model_reset();
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = rand_op();
            req_b[i*DW +: DW] = rand_op();
        end

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_tvalid", {a_tvalid, b_tvalid}, 0);
        chk("rst_tready", r_tready, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err_orphan", err_orphan, 0);
        @(negedge clk);
        aresetn = 1'b1;

        // 1: single operation from requester 2, 1.0 + 2.0
        req_a[2*DW +: DW] = 32'h3F800000;
        req_b[2*DW +: DW] = 32'h40000000;
        req_valid = 4'b0100;
        #1 chk("t1_req_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        #1 chk("t1_outstanding1", outstanding, 1);
        chk("t1_tvalid", {a_tvalid, b_tvalid}, 2'b11);
        tick();
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            #1;
            if (rsp_valid != '0) begin
                seen = 1;
                chk("t1_rsp_valid", rsp_valid, 4'b0100);
                chk("t1_rsp_data", rsp_data, 32'h40400000);
            end
            tick();
        end
        chk("t1_result_seen", seen, 1);
        #1 chk("t1_outstanding0", outstanding, 0);

        // 2: fairness with all requesters continuously valid
        obs_glog.delete();
        start = m_ptr;
        req_valid = '1;
        for (int k = 0; k < 80 && obs_glog.size() < 12; k++) tick();
        chk("t2_grant_count", obs_glog.size(), 12);
        for (int k = 0; k < 12 && k < obs_glog.size(); k++)
            chk("t2_grant_order", obs_glog[k], (start + k) % NR);
        drain();

        // 3: operand b held off for 5 cycles after a is taken
        req_valid = '1;
        tick();
        b_tready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1 chk("t3_no_grant", req_ready, 0);
            tick();
        end
        b_tready = 1'b1;
        tick();
        tick();
        drain();

        // 4: result backpressure on requester 1 until the tag FIFO is full
        rsp_ready = 4'b1101;
        req_valid = '1;
        for (int k = 0; k < 100 && m_cnt < TD; k++) tick();
        #1 chk("t4_full_outstanding", outstanding, TD);
        chk("t4_no_ready", req_ready, 0);
        tick();
        tick();
        rsp_ready = '1;
        drain();

        // 5: result with no tag pending
        force_orphan = 1'b1;
        tick();
        tick();
        force_orphan = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        #1 chk("t5_orphan_sticky", err_orphan, 1);

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            req_valid = NR'($urandom);
            rsp_ready = NR'($urandom);
            a_tready  = ($urandom_range(0, 3) != 0);
            b_tready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        a_tready  = 1'b1;
        b_tready  = 1'b1;
        rsp_ready = '1;
        drain();

        // 6: reset while ops are in flight and an issue is in progress
        rsp_ready = '0;
        req_valid = '1;
        for (int k = 0; k < 40 && !(m_cnt == 3 && m_issuing); k++) tick();
        chk("t6_setup", {outstanding, a_tvalid | b_tvalid}, {4'd3, 1'b1});
        aresetn = 1'b0;
        model_reset();
        #1;
        chk("t6_req_ready", req_ready, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_tvalid", {a_tvalid, b_tvalid}, 0);
        chk("t6_tready", r_tready, 0);
        chk("t6_outstanding", outstanding, 0);
        chk("t6_err_orphan", err_orphan, 0);
        @(negedge clk);
        aresetn   = 1'b1;
        rsp_ready = '1;
        obs_glog.delete();
        tick();
        chk("t6_first_grant", (obs_glog.size() > 0) ? obs_glog[0] : 99, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
